// File: rtl/ram_arbiter_pkg.sv
// Shared types and widths for the CPU/DMA system RAM arbiter.
package ram_arbiter_pkg;

  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned BURST_W  = 4;
  localparam int unsigned STARVE_W = 8;

  typedef enum logic {
    CPU_OWN = 1'b0,
    DMA_OWN = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_DMA  = 2'd2
  } rd_tag_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } ram_req_t;

endpackage

// File: rtl/ram_arbiter_fsm.sv
// Ownership state, burst/starvation counters and the same-cycle grant decision.
module ram_arbiter_fsm
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned BURST_MAX  = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_sel,
  input  logic dma_req,
  output logic grant_cpu,
  output logic grant_dma
);

  arb_state_e          state_q, state_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CPU_OWN;
      burst_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      starve_q <= starve_d;
    end
  end

  // Grants are held off during reset so the RAM sees no strobe.
  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    starve_d  = starve_q;
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (!reset) begin
      case (state_q)
        CPU_OWN: begin
          if (dma_req && (starve_q == STARVE_W'(STARVE_MAX))) grant_dma = 1'b1;
          else if (cpu_sel)                                   grant_cpu = 1'b1;
          else if (dma_req)                                   grant_dma = 1'b1;
        end
        DMA_OWN: begin
          if (dma_req && (burst_q < BURST_W'(BURST_MAX))) grant_dma = 1'b1;
          else                                            grant_cpu = cpu_sel;
        end
        default: ;
      endcase

      if (grant_dma) begin
        if (state_q == CPU_OWN) begin
          state_d  = DMA_OWN;
          burst_d  = BURST_W'(1);
          starve_d = '0;
        end else begin
          burst_d = burst_q + BURST_W'(1);
        end
      end else begin
        // Any cycle a pending DMA request is refused counts toward preemption.
        state_d = CPU_OWN;
        burst_d = '0;
        if (dma_req && (starve_q != '1)) starve_d = starve_q + STARVE_W'(1);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// CPU/DMA arbiter in front of the single-ported system RAM.
// Optional stall statistics counter enabled by RAM_ARBITER_STATS_EN.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned BURST_MAX  = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_sel,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_rdy,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_din,
  output logic              dma_gnt,
  output logic              dma_valid,
  output logic [DATA_W-1:0] dma_dout,
`ifdef RAM_ARBITER_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       cpu_stall_cnt,
`endif
  output logic              ram_sel,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  logic        grant_cpu, grant_dma;
  ram_req_t    cpu_req, dma_req_p, ram_req;
  rd_tag_e     tag_q;
  logic [DATA_W-1:0] cpu_hold_q, dma_hold_q;

  ram_arbiter_fsm #(
    .BURST_MAX  (BURST_MAX),
    .STARVE_MAX (STARVE_MAX)
  ) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .cpu_sel   (cpu_sel),
    .dma_req   (dma_req),
    .grant_cpu (grant_cpu),
    .grant_dma (grant_dma)
  );

  assign cpu_req   = '{we: cpu_we, addr: cpu_addr, din: cpu_din};
  assign dma_req_p = '{we: dma_we, addr: dma_addr, din: dma_din};

  always_comb begin
    ram_req = '0;
    if (grant_cpu)      ram_req = cpu_req;
    else if (grant_dma) ram_req = dma_req_p;
  end

  assign ram_sel  = grant_cpu | grant_dma;
  assign ram_we   = ram_req.we;
  assign ram_addr = ram_req.addr;
  assign ram_din  = ram_req.din;

  assign dma_gnt = grant_dma;
  assign cpu_rdy = !(cpu_sel && grant_dma);

  // Tag each granted read with its owner; the RAM answers one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q      <= TAG_NONE;
      cpu_hold_q <= '0;
      dma_hold_q <= '0;
    end else begin
      if (grant_cpu && !cpu_we)      tag_q <= TAG_CPU;
      else if (grant_dma && !dma_we) tag_q <= TAG_DMA;
      else                           tag_q <= TAG_NONE;
      if (tag_q == TAG_CPU) cpu_hold_q <= ram_dout;
      if (tag_q == TAG_DMA) dma_hold_q <= ram_dout;
    end
  end

  // Return data passes straight through in the answer cycle, then holds.
  assign cpu_dout  = (tag_q == TAG_CPU) ? ram_dout : cpu_hold_q;
  assign dma_dout  = (tag_q == TAG_DMA) ? ram_dout : dma_hold_q;
  assign dma_valid = (tag_q == TAG_DMA);

`ifdef RAM_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || stats_clr)                       cpu_stall_cnt <= '0;
    else if (!cpu_rdy && (cpu_stall_cnt != '1))   cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
  end
`endif

endmodule
